opcode_issue_ctrl: RTL and testbench

Sequences opcode/data transactions from an upstream source into the downstream execution datapath. Every transaction passes a parity validity check before issue. Failing transactions are dropped and counted. The block owns a valid/ready handshake on both sides, a four-state FSM, a saturating error counter and a sticky error flag.

---
 rtl/opcode_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_opcode_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_issue_ctrl.sv
// opcode_issue_ctrl: parity-checked opcode/data issue controller.
// Accepts one transaction in IDLE, checks it for one cycle in CHECK, then
// either issues it downstream (ISSUE, valid/ready handshake) or drops it
// (REJECT, one-cycle error pulse, sticky flag, saturating counter).
// Optional macro X_CHECK_EN (simulation only): additionally rejects a
// transaction whose held opcode/data contain X or Z bits and reports them.
module opcode_issue_ctrl #(
    parameter int OPCODE_W = 8,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_parity,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [DATA_W-1:0]   out_data,
    output logic                err_pulse,
    output logic                err_sticky,
    output logic [CNT_W-1:0]    err_cnt,
    input  logic                err_clr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_ISSUE  = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    state_t                r_state;
    logic [OPCODE_W-1:0]   r_opcode_q;
    logic [DATA_W-1:0]     r_data_q;
    logic                  r_parity_q;
    logic [OPCODE_W-1:0]   r_out_opcode;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_err_sticky;
    logic [CNT_W-1:0]      r_err_cnt;

    logic [OPCODE_W+DATA_W-1:0] w_hold;
    logic                       w_parity_fail;
    logic                       w_x_fail;
    logic                       w_reject;

    assign w_hold        = {r_opcode_q, r_data_q};
    // Even parity: XOR of payload and parity bit must be zero for a good transaction.
    assign w_parity_fail = (^w_hold) ^ r_parity_q;

`ifdef X_CHECK_EN
    // Any X/Z bit makes (v ^ ~v) differ from all-ones; case inequality catches it.
    assign w_x_fail = ((w_hold ^ ~w_hold) !== {(OPCODE_W+DATA_W){1'b1}});
`else
    assign w_x_fail = 1'b0;
`endif

    assign w_reject = w_parity_fail | w_x_fail;

    // Handshake and error pulse are decoded straight from the state register.
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_ISSUE);
    assign err_pulse  = (r_state == S_REJECT);
    assign out_opcode = r_out_opcode;
    assign out_data   = r_out_data;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

    // Control FSM, holding/output registers and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_opcode_q   <= '0;
            r_data_q     <= '0;
            r_parity_q   <= 1'b0;
            r_out_opcode <= '0;
            r_out_data   <= '0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opcode_q <= in_opcode;
                        r_data_q   <= in_data;
                        r_parity_q <= in_parity;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_state <= S_REJECT;
                    end else begin
                        // Output payload is copied once so it stays frozen during a stall
                        // and keeps its last value while idle.
                        r_out_opcode <= r_opcode_q;
                        r_out_data   <= r_data_q;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REJECT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Clear has priority over a coincident rejection.
            if (err_clr) begin
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
            end else if (r_state == S_REJECT) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef X_CHECK_EN
    // Report payloads rejected for unknown bits.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_CHECK) && w_x_fail) begin
            $display("opcode_issue_ctrl: X/Z payload rejected opcode=%b data=%b",
                     r_opcode_q, r_data_q);
        end
    end
`endif

endmodule

// File: tb/tb_opcode_issue_ctrl.sv
// Self-checking bench for opcode_issue_ctrl (CNT_W=2 to reach saturation quickly).
module tb_opcode_issue_ctrl;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_opcode = '0;
    logic [7:0] in_data = '0;
    logic       in_parity = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_opcode;
    logic [7:0] out_data;
    logic       err_pulse;
    logic       err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic       err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: error count and sticky flag.
    int model_cnt    = 0;
    bit model_sticky = 0;

    opcode_issue_ctrl #(.OPCODE_W(8), .DATA_W(8), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Parity is correct when the total number of ones (payload + parity bit) is even.
    function automatic bit parity_good(input logic [7:0] op, input logic [7:0] d, input logic p);
        return ((($countones(op) + $countones(d) + int'(p)) % 2) == 0);
    endfunction

    function automatic logic good_parity_bit(input logic [7:0] op, input logic [7:0] d);
        return logic'(($countones(op) + $countones(d)) % 2);
    endfunction

    // One complete transaction from IDLE back to IDLE, checked cycle by cycle.
    task automatic send(input logic [7:0] op, input logic [7:0] d, input logic p,
                        input int stall, input bit clr_in_reject, input string tag);
        bit good;
        good      = parity_good(op, d, p);
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        in_parity = p;
        out_ready = (stall == 0);
        tick();
        // CHECK cycle
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL %s check_cycle: in_ready=%b out_valid=%b err_pulse=%b, required 0/0/0",
                     tag, in_ready, out_valid, err_pulse);
        end
        in_valid  = 1'b0;
        in_opcode = 8'($urandom);
        in_data   = 8'($urandom);
        in_parity = 1'($urandom);
        tick();
        if (good) begin
            for (int i = 0; i <= stall; i++) begin
                if (i == stall) out_ready = 1'b1;
                n_tests++;
                if (out_valid !== 1'b1 || out_opcode !== op || out_data !== d ||
                    in_ready !== 1'b0 || err_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s issue[%0d]: valid=%b op=%h data=%h in_ready=%b err_pulse=%b, required 1 %h %h 0 0",
                             tag, i, out_valid, out_opcode, out_data, in_ready, err_pulse, op, d);
                end
                tick();
            end
        end else begin
            n_tests++;
            if (err_pulse !== 1'b1 || out_valid !== 1'b0 || int'(err_cnt) !== model_cnt) begin
                n_fail++;
                $display("FAIL %s reject_cycle: err_pulse=%b out_valid=%b err_cnt=%0d, required 1 0 %0d",
                         tag, err_pulse, out_valid, err_cnt, model_cnt);
            end
            if (clr_in_reject) err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            if (clr_in_reject) begin
                model_cnt    = 0;
                model_sticky = 0;
            end else begin
                model_cnt    = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
                model_sticky = 1;
            end
        end
        // Back in IDLE
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_pulse !== 1'b0 ||
            int'(err_cnt) !== model_cnt || err_sticky !== model_sticky) begin
            n_fail++;
            $display("FAIL %s idle_after: in_ready=%b out_valid=%b err_pulse=%b err_cnt=%0d sticky=%b, required 1 0 0 %0d %b",
                     tag, in_ready, out_valid, err_pulse, err_cnt, err_sticky, model_cnt, model_sticky);
        end
        $display("[TB] %s op=%h data=%h par=%b stall=%0d -> %s cnt=%0d", tag, op, d, p, stall,
                 good ? "issued" : "rejected", model_cnt);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #13;
        rst_n = 1'b1;
        model_cnt    = 0;
        model_sticky = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_opcode !== 8'h00 || out_data !== 8'h00 ||
            err_pulse !== 1'b0 || err_sticky !== 1'b0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b op=%h data=%h pulse=%b sticky=%b cnt=%0d, required 1 0 00 00 0 0 0",
                     in_ready, out_valid, out_opcode, out_data, err_pulse, err_sticky, err_cnt);
        end
        apply_reset();
    endtask

    task automatic test_directed();
        send(8'h10, 8'haa, 1'b1, 0, 1'b0, "good_10_aa");
        send(8'h10, 8'haa, 1'b0, 0, 1'b0, "bad_10_aa");
    endtask

    task automatic test_stall();
        send(8'h3c, 8'h01, good_parity_bit(8'h3c, 8'h01), 5, 1'b0, "stall5");
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] op;
            logic [7:0] d;
            op = 8'($urandom);
            d  = 8'($urandom);
            send(op, d, ~good_parity_bit(op, d), 0, 1'b0, "sat");
        end
        send(8'h55, 8'h0f, ~good_parity_bit(8'h55, 8'h0f), 0, 1'b1, "clr_in_reject");
    endtask

    task automatic test_clr_idle();
        send(8'h01, 8'h00, 1'b0, 0, 1'b0, "pre_clr_bad");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        model_cnt    = 0;
        model_sticky = 0;
        n_tests++;
        if (err_cnt !== '0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_idle: err_cnt=%0d sticky=%b in_ready=%b, required 0 0 1", err_cnt, err_sticky, in_ready);
        end
        $display("[TB] clr_idle cnt=%0d sticky=%b", err_cnt, err_sticky);
    endtask

    task automatic test_reset_mid();
        send(8'hff, 8'h00, 1'b1, 0, 1'b0, "pre_rst_bad");
        in_valid  = 1'b1;
        in_opcode = 8'h81;
        in_data   = 8'h7e;
        in_parity = good_parity_bit(8'h81, 8'h7e);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        // Now stalled in ISSUE; assert reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== '0 || err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b err_cnt=%0d sticky=%b, required 0 1 0 0",
                     out_valid, in_ready, err_cnt, err_sticky);
        end
        $display("[TB] reset_mid out_valid=%b in_ready=%b", out_valid, in_ready);
        #10;
        rst_n = 1'b1;
        model_cnt    = 0;
        model_sticky = 0;
        tick();
        send(8'h42, 8'h24, good_parity_bit(8'h42, 8'h24), 1, 1'b0, "post_rst");
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        in_valid  = 1'b1;
        in_opcode = 8'h07;
        in_data   = 8'h70;
        in_parity = good_parity_bit(8'h07, 8'h70);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid === 1'b1) issued++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (issued !== 4) begin
            n_fail++;
            $display("FAIL back_to_back_issue: issued=%0d in 12 cycles, required 4", issued);
        end
        $display("[TB] back_to_back issued=%0d", issued);
        // Rejections at full rate
        issued = 0;
        in_valid  = 1'b1;
        in_parity = ~good_parity_bit(8'h07, 8'h70);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (err_pulse === 1'b1) issued++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        model_cnt    = CNT_MAX;
        model_sticky = 1;
        n_tests++;
        if (issued !== 4 || int'(err_cnt) !== model_cnt || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_reject: pulses=%0d err_cnt=%0d out_valid=%b, required 4 %0d 0",
                     issued, err_cnt, out_valid, model_cnt);
        end
        $display("[TB] back_to_back rejects=%0d cnt=%0d", issued, err_cnt);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            logic [7:0] d;
            op = 8'($urandom);
            d  = 8'($urandom);
            send(op, d, 1'($urandom), $urandom_range(0, 3), 1'b0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_saturation();
        test_clr_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
